// File: rtl/transfer_pkg.sv
// Shared types and constants for the two-requester byte-to-word transfer arbiter.
package transfer_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD + 1);
   localparam int LANE_IDX_W     = $clog2(BYTES_PER_WORD);
   localparam int WORD_W         = 8 * BYTES_PER_WORD;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_OUTPUT  = 2'd2
   } state_t;

   typedef logic src_t;

endpackage

// File: rtl/byte_lane_packer.sv
// Packs accepted bytes into successive lanes of a word and counts them.
// Data is cleared on reset and on clear so unfilled lanes always read as zero.
module byte_lane_packer
   import transfer_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en_i,
   input  logic [7:0]            wr_byte_i,
   input  logic                  clr_i,
   output logic [WORD_W-1:0]     word_o,
   output logic [BYTE_CNT_W-1:0] cnt_o
);

   logic [WORD_W-1:0]     word_q, word_d;
   logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      if (clr_i) begin
         word_d = '0;
         cnt_d  = '0;
      end else if (wr_en_i) begin
         word_d[8*cnt_q[LANE_IDX_W-1:0] +: 8] = wr_byte_i;
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
      end
   end

   assign word_o = word_q;
   assign cnt_o  = cnt_q;

endmodule

// File: rtl/transfer_arbiter.sv
// Round-robin arbiter that assembles 4-byte words from one of two byte requesters.
// Optional stall-timeout flush of partial words is enabled by TRANSFER_ARB_TIMEOUT_EN.
module transfer_arbiter
   import transfer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in0_data,
   input  logic [7:0]  in1_data,
   input  logic        in0_valid,
   input  logic        in1_valid,
   output logic        in0_ready,
   output logic        in1_ready,
   output logic [31:0] out_data,
   output logic        out_src,
   output logic [2:0]  out_bytes,
   output logic        out_valid,
   input  logic        out_ready
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("transfer_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   state_t                state_q, state_d;
   src_t                  grant_q, grant_d;
   src_t                  last_grant_q, last_grant_d;
   logic                  gnt_valid, acc, clr, flush;
   logic [7:0]            wr_byte;
   logic [WORD_W-1:0]     word;
   logic [BYTE_CNT_W-1:0] byte_cnt;

   assign gnt_valid = grant_q ? in1_valid : in0_valid;
   assign wr_byte   = grant_q ? in1_data : in0_data;
   assign acc       = (state_q == ST_COLLECT) && gnt_valid;
   assign clr       = (state_q == ST_OUTPUT) && out_ready;

   byte_lane_packer u_packer (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (acc),
      .wr_byte_i (wr_byte),
      .clr_i     (clr),
      .word_o    (word),
      .cnt_o     (byte_cnt)
   );

`ifdef TRANSFER_ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             stall;

   // Only consecutive stalls on a partially filled word count toward the flush.
   assign stall = (state_q == ST_COLLECT) && (byte_cnt != '0) && !gnt_valid;
   assign flush = stall && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
   assign tmo_d = stall ? tmo_q + 1'b1 : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) tmo_q <= '0;
      else     tmo_q <= tmo_d;
   end
`else
   assign flush = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      case (state_q)
         ST_IDLE: begin
            if (in0_valid || in1_valid) begin
               grant_d = (in0_valid && in1_valid) ? ~last_grant_q : in1_valid;
               state_d = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if ((acc && byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1)) || flush)
               state_d = ST_OUTPUT;
         end
         ST_OUTPUT: begin
            if (out_ready) begin
               last_grant_d = grant_q;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in0_ready = 1'b0;
      in1_ready = 1'b0;
      out_valid = 1'b0;
      out_src   = 1'b0;
      out_bytes = '0;
      out_data  = word;
      case (state_q)
         ST_COLLECT: begin
            in0_ready = !grant_q;
            in1_ready = grant_q;
         end
         ST_OUTPUT: begin
            out_valid = 1'b1;
            out_src   = grant_q;
            out_bytes = byte_cnt;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_transfer_arbiter.sv
// Self-checking bench for transfer_arbiter: directed scenarios plus a randomized
// run scored against per-requester byte streams.
module tb_transfer_arbiter;

`ifdef TRANSFER_ARB_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 255;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in0_data, in1_data;
   logic        in0_valid, in1_valid;
   logic        in0_ready, in1_ready;
   logic [31:0] out_data;
   logic        out_src;
   logic [2:0]  out_bytes;
   logic        out_valid;
   logic        out_ready;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   transfer_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .in0_data  (in0_data),
      .in1_data  (in1_data),
      .in0_valid (in0_valid),
      .in1_valid (in1_valid),
      .in0_ready (in0_ready),
      .in1_ready (in1_ready),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_bytes (out_bytes),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   function automatic logic [31:0] seq_word(input logic [7:0] b0);
      return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
   endfunction

   task automatic drive_idle();
      in0_valid = 1'b0; in1_valid = 1'b0;
      in0_data  = 8'h00; in1_data  = 8'h00;
      out_ready = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      drive_idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Offers n bytes from one requester; returns handshakes done and whether out_valid was seen.
   task automatic push_bytes(input bit src, input logic [7:0] data [4], input int n,
                             output int sent, output bit saw_out);
      sent = 0;
      saw_out = 1'b0;
      if (src) begin in1_valid = 1'b1; in1_data = data[0]; end
      else     begin in0_valid = 1'b1; in0_data = data[0]; end
      for (int c = 0; c < 40 && sent < n; c++) begin
         @(negedge clk);
         if (out_valid) saw_out = 1'b1;
         if (src ? (in1_valid && in1_ready) : (in0_valid && in0_ready)) sent++;
         next_cycle();
         if (sent < n) begin
            if (src) in1_data = data[sent]; else in0_data = data[sent];
         end else begin
            if (src) in1_valid = 1'b0; else in0_valid = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({out_valid, in0_ready, in1_ready, out_src, out_bytes, out_data} !== 39'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b r0=%b r1=%b src=%b bytes=%0d data=%h, expected all zero",
                  out_valid, in0_ready, in1_ready, out_src, out_bytes, out_data);
      end
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({out_valid, in0_ready, in1_ready} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_idle: got v=%b r0=%b r1=%b, expected 000", out_valid, in0_ready, in1_ready);
      end
   endtask

   task automatic test_single_requester();
      logic [7:0] b [4];
      int sent;
      bit saw;
      apply_reset();
      b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
      out_ready = 1'b1;
      push_bytes(1'b0, b, 4, sent, saw);
      n_tests++;
      if (sent != 4 || saw) begin
         n_fail++;
         $display("FAIL single_collect: got sent=%0d early_valid=%b, expected 4 and 0", sent, saw);
      end
      @(negedge clk);
      n_tests++;
      if ({out_valid, out_src, out_bytes, out_data} !== {1'b1, 1'b0, 3'd4, 32'h44332211}) begin
         n_fail++;
         $display("FAIL single_word: got v=%b src=%b bytes=%0d data=%h, expected v=1 src=0 bytes=4 data=44332211",
                  out_valid, out_src, out_bytes, out_data);
      end
      next_cycle();
      @(negedge clk);
      n_tests++;
      if ({out_valid, in0_ready, in1_ready} !== 3'b000) begin
         n_fail++;
         $display("FAIL single_after: got v=%b r0=%b r1=%b, expected 000", out_valid, in0_ready, in1_ready);
      end
   endtask

   task automatic test_round_robin();
      int nb [2];
      int wc [2];
      int words;
      bit exp_src;
      logic [7:0] base;
      apply_reset();
      nb = '{0, 0};
      wc = '{0, 0};
      words = 0;
      in0_valid = 1'b1; in1_valid = 1'b1;
      in0_data = 8'h00; in1_data = 8'h80;
      out_ready = 1'b1;
      for (int c = 0; c < 80 && words < 3; c++) begin
         @(negedge clk);
         exp_src = words[0];
         n_tests++;
         if ((exp_src ? in0_ready : in1_ready) !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_nongranted_ready: word %0d got ready high on requester %0d", words, !exp_src);
         end
         if (in0_valid && in0_ready) nb[0]++;
         if (in1_valid && in1_ready) nb[1]++;
         if (out_valid && out_ready) begin
            base = exp_src ? 8'(8'h80 + 4 * wc[1]) : 8'(4 * wc[0]);
            n_tests++;
            if (out_src !== exp_src || out_data !== seq_word(base)) begin
               n_fail++;
               $display("FAIL rr_word: word %0d got src=%b data=%h, expected src=%b data=%h",
                        words, out_src, out_data, exp_src, seq_word(base));
            end
            wc[exp_src]++;
            words++;
         end
         next_cycle();
         in0_data = 8'(nb[0]);
         in1_data = 8'(8'h80 + nb[1]);
      end
      n_tests++;
      if (words != 3) begin
         n_fail++;
         $display("FAIL rr_words: got %0d words, expected 3", words);
      end
      drive_idle();
   endtask

   task automatic test_backpressure();
      logic [7:0] b [4];
      logic [31:0] exp;
      int sent;
      bit saw;
      apply_reset();
      for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
      exp = {b[3], b[2], b[1], b[0]};
      push_bytes(1'b1, b, 4, sent, saw);
      n_tests++;
      if (sent != 4) begin
         n_fail++;
         $display("FAIL bp_collect: got sent=%0d, expected 4", sent);
      end
      in0_valid = 1'b1; in1_valid = 1'b1; in0_data = 8'h5A; in1_data = 8'hA5;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_tests++;
         if ({out_valid, out_src, out_bytes, out_data, in0_ready, in1_ready} !==
             {1'b1, 1'b1, 3'd4, exp, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_hold: cycle %0d got v=%b src=%b bytes=%0d data=%h r0=%b r1=%b, expected v=1 src=1 bytes=4 data=%h r0=0 r1=0",
                     c, out_valid, out_src, out_bytes, out_data, in0_ready, in1_ready, exp);
         end
         next_cycle();
      end
      out_ready = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
         n_fail++;
         $display("FAIL bp_release: got v=%b data=%h, expected v=1 data=%h", out_valid, out_data, exp);
      end
      next_cycle();
      out_ready = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({out_valid, in0_ready, in1_ready} !== 3'b000) begin
         n_fail++;
         $display("FAIL bp_idle: got v=%b r0=%b r1=%b, expected 000", out_valid, in0_ready, in1_ready);
      end
   endtask

   task automatic test_stall();
      logic [7:0] b [4];
      logic [7:0] hi [4];
      int sent;
      bit saw;
      int early;
      apply_reset();
      for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
      hi[0] = b[2]; hi[1] = b[3]; hi[2] = 8'h00; hi[3] = 8'h00;
      out_ready = 1'b1;
      push_bytes(1'b1, b, 2, sent, saw);
      early = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (out_valid) early++;
         next_cycle();
      end
      n_tests++;
      if (early != 0 || saw) begin
         n_fail++;
         $display("FAIL stall_no_output: got %0d output cycles during stall, expected 0", early);
      end
      push_bytes(1'b1, hi, 2, sent, saw);
      @(negedge clk);
      n_tests++;
      if ({out_valid, out_src, out_bytes, out_data} !== {1'b1, 1'b1, 3'd4, b[3], b[2], b[1], b[0]}) begin
         n_fail++;
         $display("FAIL stall_word: got v=%b src=%b bytes=%0d data=%h, expected v=1 src=1 bytes=4 data=%h",
                  out_valid, out_src, out_bytes, out_data, {b[3], b[2], b[1], b[0]});
      end
      drive_idle();
   endtask

`ifdef TRANSFER_ARB_TIMEOUT_EN
   task automatic test_timeout();
      logic [7:0] b [4];
      int sent;
      bit saw;
      int lows;
      bit got;
      apply_reset();
      b[0] = 8'hAA; b[1] = 8'hBB; b[2] = 8'h00; b[3] = 8'h00;
      push_bytes(1'b0, b, 2, sent, saw);
      lows = 0;
      got = 1'b0;
      for (int c = 0; c < 30 && !got; c++) begin
         @(negedge clk);
         if (out_valid) got = 1'b1;
         else begin
            lows++;
            next_cycle();
         end
      end
      n_tests++;
      if (!got || lows != TMO) begin
         n_fail++;
         $display("FAIL timeout_delay: got flush=%b after %0d stall cycles, expected flush after %0d", got, lows, TMO);
      end
      n_tests++;
      if ({out_src, out_bytes, out_data} !== {1'b0, 3'd2, 32'h0000BBAA}) begin
         n_fail++;
         $display("FAIL timeout_word: got src=%b bytes=%0d data=%h, expected src=0 bytes=2 data=0000bbaa",
                  out_src, out_bytes, out_data);
      end
      out_ready = 1'b1;
      next_cycle();
      drive_idle();
   endtask
`endif

   task automatic test_async_reset();
      logic [7:0] b [4];
      logic [7:0] nb [4];
      int sent;
      bit saw;
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         b[k]  = 8'($urandom_range(1, 255));
         nb[k] = 8'($urandom);
      end
      push_bytes(1'b0, b, 3, sent, saw);
      n_tests++;
      if (in0_ready !== 1'b1 || out_data !== {8'h00, b[2], b[1], b[0]}) begin
         n_fail++;
         $display("FAIL arst_partial: got r0=%b data=%h, expected r0=1 data=%h",
                  in0_ready, out_data, {8'h00, b[2], b[1], b[0]});
      end
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if ({out_valid, in0_ready, in1_ready, out_src, out_bytes, out_data} !== 39'd0) begin
         n_fail++;
         $display("FAIL arst_immediate: got v=%b r0=%b r1=%b src=%b bytes=%0d data=%h, expected all zero",
                  out_valid, in0_ready, in1_ready, out_src, out_bytes, out_data);
      end
      next_cycle();
      rst = 1'b0;
      in1_valid = 1'b1; in1_data = 8'h5A;
      out_ready = 1'b1;
      push_bytes(1'b0, nb, 4, sent, saw);
      @(negedge clk);
      n_tests++;
      if ({out_valid, out_src, out_bytes, out_data} !== {1'b1, 1'b0, 3'd4, nb[3], nb[2], nb[1], nb[0]}) begin
         n_fail++;
         $display("FAIL arst_next_word: got v=%b src=%b bytes=%0d data=%h, expected v=1 src=0 bytes=4 data=%h",
                  out_valid, out_src, out_bytes, out_data, {nb[3], nb[2], nb[1], nb[0]});
      end
      drive_idle();
   endtask

   task automatic test_random();
      logic [7:0] s0 [$];
      logic [7:0] s1 [$];
      int n0, n1, p0, p1, w0, w1, bts;
      bit pend;
      logic [31:0] pd, exp;
      logic ps;
      logic [2:0] pb;
      apply_reset();
      n0 = 4 * $urandom_range(3, 6);
      n1 = 4 * $urandom_range(3, 6);
      for (int i = 0; i < n0; i++) s0.push_back(8'($urandom));
      for (int i = 0; i < n1; i++) s1.push_back(8'($urandom));
      p0 = 0; p1 = 0; w0 = 0; w1 = 0;
      pend = 1'b0; pd = '0; ps = 1'b0; pb = '0;
      for (int c = 0; c < 4000 && !(w0 == n0 && w1 == n1); c++) begin
         in0_valid = (p0 < n0) && ($urandom_range(0, 3) != 0);
         in0_data  = (p0 < n0) ? s0[p0] : 8'h00;
         in1_valid = (p1 < n1) && ($urandom_range(0, 3) != 0);
         in1_data  = (p1 < n1) ? s1[p1] : 8'h00;
         out_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         n_tests++;
         if (in0_ready && in1_ready) begin
            n_fail++;
            $display("FAIL rand_ready_excl: cycle %0d both readys high", c);
         end
         if (pend) begin
            n_tests++;
            if ({out_valid, out_src, out_bytes, out_data} !== {1'b1, ps, pb, pd}) begin
               n_fail++;
               $display("FAIL rand_hold: cycle %0d got v=%b src=%b bytes=%0d data=%h, expected v=1 src=%b bytes=%0d data=%h",
                        c, out_valid, out_src, out_bytes, out_data, ps, pb, pd);
            end
         end
         if (in0_valid && in0_ready) p0++;
         if (in1_valid && in1_ready) p1++;
         if (out_valid && out_ready) begin
            bts = int'(out_bytes);
`ifndef TRANSFER_ARB_TIMEOUT_EN
            n_tests++;
            if (out_bytes !== 3'd4) begin
               n_fail++;
               $display("FAIL rand_bytes: got %0d, expected 4", out_bytes);
            end
`endif
            if (bts < 1 || bts > 4 || (out_src ? (w1 + bts > n1) : (w0 + bts > n0))) begin
               n_tests++;
               n_fail++;
               $display("FAIL rand_count: got src=%b bytes=%0d with %0d/%0d bytes left", out_src, bts,
                        out_src ? n1 - w1 : n0 - w0, out_src ? n1 : n0);
               bts = 0;
            end else begin
               exp = '0;
               for (int k = 0; k < bts; k++) exp[8*k +: 8] = out_src ? s1[w1 + k] : s0[w0 + k];
               n_tests++;
               if (out_data !== exp) begin
                  n_fail++;
                  $display("FAIL rand_word: src=%b got %h, expected %h", out_src, out_data, exp);
               end
               if (out_src) w1 += bts; else w0 += bts;
            end
         end
         pend = out_valid && !out_ready;
         pd = out_data; ps = out_src; pb = out_bytes;
         next_cycle();
      end
      n_tests++;
      if (w0 != n0 || w1 != n1) begin
         n_fail++;
         $display("FAIL rand_complete: got %0d/%0d and %0d/%0d bytes out, expected all", w0, n0, w1, n1);
      end
      drive_idle();
   endtask

   initial begin
      rst = 1'b1;
      drive_idle();
      test_reset();
      test_single_requester();
      test_round_robin();
      test_backpressure();
      test_stall();
`ifdef TRANSFER_ARB_TIMEOUT_EN
      test_timeout();
`endif
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
